// File: rtl/bpred_pht_write_sched_if.sv
// Bundles the W-stage update offer and the PHT write-port signals.
// The scheduler takes the slave side; the update source / PHT side takes the master side.
interface bpred_pht_write_sched_if #(
  parameter int k = 10
);
  logic         UpdValid;
  logic [k-1:0] UpdIndex;
  logic [1:0]   UpdState;
  logic         PHTWe;
  logic [k-1:0] PHTWa;
  logic [1:0]   PHTWd;

  modport master (
    output UpdValid, UpdIndex, UpdState,
    input  PHTWe, PHTWa, PHTWd
  );

  modport slave (
    input  UpdValid, UpdIndex, UpdState,
    output PHTWe, PHTWa, PHTWd
  );
endinterface

// File: rtl/bpred_pht_write_sched.sv
// Owns the PHT write port: sweeps the table to INITVAL after reset/invalidate,
// queues retire-stage counter updates during the sweep and drains them in order.
module bpred_pht_write_sched #(
  parameter int         k       = 10,
  parameter int         QDEPTH  = 4,
  parameter logic [1:0] INITVAL = 2'b01
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      StallW,
  input  logic                      FlushW,
  input  logic                      InvalidateReq,
  bpred_pht_write_sched_if.slave    phtBus,
  output logic                      InitBusy,
  output logic                      UpdDropped,
  output logic [$clog2(QDEPTH):0]   QCount
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);
  localparam logic [k-1:0]  SWEEP_LAST = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t        stateReg, stateNext;
  logic [k-1:0]  sweepIdxReg, sweepIdxNext;
  logic [PW-1:0] rdPtrReg, rdPtrNext;
  logic [PW-1:0] wrPtrReg, wrPtrNext;
  logic [CW-1:0] countReg, countNext;
  logic [k-1:0]  slotIdxReg [QDEPTH];
  logic [1:0]    slotStReg  [QDEPTH];

  logic          accept, full, empty, push, pop, dropped;
  logic          weComb;
  logic [k-1:0]  waComb;
  logic [1:0]    wdComb;

  assign accept = phtBus.UpdValid & ~StallW & ~FlushW;
  assign full   = (countReg == FULL_COUNT);
  assign empty  = (countReg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= INIT;
      sweepIdxReg <= '0;
      rdPtrReg    <= '0;
      wrPtrReg    <= '0;
      countReg    <= '0;
    end else begin
      stateReg    <= stateNext;
      sweepIdxReg <= sweepIdxNext;
      rdPtrReg    <= rdPtrNext;
      wrPtrReg    <= wrPtrNext;
      countReg    <= countNext;
    end
  end

  // Payload slots carry no reset; occupancy is tracked solely by countReg.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push && wrPtrReg == PW'(gi)) begin
        slotIdxReg[gi] <= phtBus.UpdIndex;
        slotStReg[gi]  <= phtBus.UpdState;
      end
    end
  end

  always_comb begin
    stateNext    = stateReg;
    sweepIdxNext = sweepIdxReg;
    weComb       = 1'b0;
    waComb       = sweepIdxReg;
    wdComb       = INITVAL;
    push         = 1'b0;
    pop          = 1'b0;

    case (stateReg)
      INIT: begin
        weComb       = 1'b1;
        sweepIdxNext = sweepIdxReg + 1'b1;
        if (sweepIdxReg == SWEEP_LAST) stateNext = RUN;
        push         = accept & ~full;
      end
      RUN: begin
        if (!empty) begin
          weComb = 1'b1;
          waComb = slotIdxReg[rdPtrReg];
          wdComb = slotStReg[rdPtrReg];
          pop    = 1'b1;
          push   = accept;
        end else if (accept) begin
          weComb = 1'b1;
          waComb = phtBus.UpdIndex;
          wdComb = phtBus.UpdState;
        end
      end
      default: stateNext = INIT;
    endcase

    // An update accepted alongside an invalidate is silently discarded, not dropped.
    dropped = accept & full & ~pop & ~InvalidateReq;
    if (InvalidateReq) push = 1'b0;

    rdPtrNext = rdPtrReg + PW'(pop);
    wrPtrNext = wrPtrReg + PW'(push);
    countNext = countReg + CW'(push) - CW'(pop);

    if (InvalidateReq) begin
      stateNext    = INIT;
      sweepIdxNext = '0;
      rdPtrNext    = '0;
      wrPtrNext    = '0;
      countNext    = '0;
    end
  end

  assign phtBus.PHTWe = weComb & ~reset;
  assign phtBus.PHTWa = waComb;
  assign phtBus.PHTWd = wdComb;
  assign InitBusy     = (stateReg == INIT);
  assign UpdDropped   = dropped & ~reset;
  assign QCount       = reset ? '0 : countReg;

endmodule

// File: tb/tb_bpred_pht_write_sched.sv
// Directed bench for bpred_pht_write_sched (k=10, QDEPTH=4, INITVAL=01).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_bpred_pht_write_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       StallW = 1'b0;
  logic       FlushW = 1'b0;
  logic       InvalidateReq = 1'b0;
  logic       InitBusy;
  logic       UpdDropped;
  logic [2:0] QCount;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  bpred_pht_write_sched_if #(.k(10)) phtBus ();

  bpred_pht_write_sched #(.k(10), .QDEPTH(4), .INITVAL(2'b01)) dut (
    .clk           (clk),
    .reset         (reset),
    .StallW        (StallW),
    .FlushW        (FlushW),
    .InvalidateReq (InvalidateReq),
    .phtBus        (phtBus.slave),
    .InitBusy      (InitBusy),
    .UpdDropped    (UpdDropped),
    .QCount        (QCount)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(negedge clk);
    phtBus.UpdValid = 1'b0;
    phtBus.UpdIndex = '0;
    phtBus.UpdState = '0;
    InvalidateReq   = 1'b0;
    StallW          = 1'b0;
    FlushW          = 1'b0;
    cyc++;
  endtask

  task automatic offer(input logic [9:0] idx, input logic [1:0] st);
    phtBus.UpdValid = 1'b1;
    phtBus.UpdIndex = idx;
    phtBus.UpdState = st;
    $display("cyc %0d: offer update idx=0x%03h st=%b", cyc, idx, st);
  endtask

  // Leaves the bench in cycle 1 after reset release (sweep index 0).
  task automatic doReset();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    cyc = 1;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) nextCycle();
  endtask

  task automatic test_reset();
    nextCycle();
    reset = 1'b1;
    phtBus.UpdValid = 1'b1;
    #1;
    nChecks++; if (phtBus.PHTWe !== 1'b0) begin nFails++; $display("FAIL reset_we got=%b exp=0", phtBus.PHTWe); end
    nChecks++; if (UpdDropped !== 1'b0) begin nFails++; $display("FAIL reset_drop got=%b exp=0", UpdDropped); end
    nChecks++; if (QCount !== 3'd0) begin nFails++; $display("FAIL reset_qcount got=%0d exp=0", QCount); end
    nextCycle();
    reset = 1'b0;
    cyc = 1;
    for (int c = 1; c <= 1024; c++) begin
      if (c > 1) nextCycle();
      #1;
      nChecks++; if (phtBus.PHTWe !== 1'b1) begin nFails++; $display("FAIL sweep_we cyc=%0d got=%b exp=1", c, phtBus.PHTWe); end
      nChecks++; if (phtBus.PHTWa !== 10'(c - 1)) begin nFails++; $display("FAIL sweep_wa cyc=%0d got=%0d exp=%0d", c, phtBus.PHTWa, c - 1); end
      nChecks++; if (phtBus.PHTWd !== 2'b01) begin nFails++; $display("FAIL sweep_wd cyc=%0d got=%b exp=01", c, phtBus.PHTWd); end
      nChecks++; if (InitBusy !== 1'b1) begin nFails++; $display("FAIL sweep_busy cyc=%0d got=%b exp=1", c, InitBusy); end
    end
    nextCycle();
    #1;
    nChecks++; if (InitBusy !== 1'b0) begin nFails++; $display("FAIL sweep_done_busy got=%b exp=0", InitBusy); end
    nChecks++; if (phtBus.PHTWe !== 1'b0) begin nFails++; $display("FAIL sweep_done_we got=%b exp=0", phtBus.PHTWe); end
    $display("test_reset: sweep of 1024 writes observed");
  endtask

  task automatic test_queue_during_sweep();
    doReset();
    runTo(6);
    offer(10'h02A, 2'b11);
    #1;
    nChecks++; if (phtBus.PHTWa !== 10'd5) begin nFails++; $display("FAIL q1_sweep_wa got=%0d exp=5", phtBus.PHTWa); end
    nextCycle();
    #1;
    nChecks++; if (QCount !== 3'd1) begin nFails++; $display("FAIL q1_qcount got=%0d exp=1", QCount); end
    runTo(1025);
    #1;
    nChecks++; if (InitBusy !== 1'b0) begin nFails++; $display("FAIL q1_busy got=%b exp=0", InitBusy); end
    nChecks++; if (phtBus.PHTWe !== 1'b1) begin nFails++; $display("FAIL q1_we got=%b exp=1", phtBus.PHTWe); end
    nChecks++; if (phtBus.PHTWa !== 10'h02A) begin nFails++; $display("FAIL q1_wa got=0x%03h exp=0x02a", phtBus.PHTWa); end
    nChecks++; if (phtBus.PHTWd !== 2'b11) begin nFails++; $display("FAIL q1_wd got=%b exp=11", phtBus.PHTWd); end
    nextCycle();
    #1;
    nChecks++; if (QCount !== 3'd0) begin nFails++; $display("FAIL q1_qcount_after got=%0d exp=0", QCount); end
    nChecks++; if (phtBus.PHTWe !== 1'b0) begin nFails++; $display("FAIL q1_we_after got=%b exp=0", phtBus.PHTWe); end
  endtask

  task automatic test_bypass();
    nextCycle();
    offer(10'h155, 2'b10);
    #1;
    nChecks++; if (phtBus.PHTWe !== 1'b1) begin nFails++; $display("FAIL byp_we got=%b exp=1", phtBus.PHTWe); end
    nChecks++; if (phtBus.PHTWa !== 10'h155) begin nFails++; $display("FAIL byp_wa got=0x%03h exp=0x155", phtBus.PHTWa); end
    nChecks++; if (phtBus.PHTWd !== 2'b10) begin nFails++; $display("FAIL byp_wd got=%b exp=10", phtBus.PHTWd); end
    nChecks++; if (UpdDropped !== 1'b0) begin nFails++; $display("FAIL byp_drop got=%b exp=0", UpdDropped); end
    nextCycle();
    #1;
    nChecks++; if (QCount !== 3'd0) begin nFails++; $display("FAIL byp_qcount got=%0d exp=0", QCount); end
    offer(10'h0F0, 2'b11);
    StallW = 1'b1;
    #1;
    nChecks++; if (phtBus.PHTWe !== 1'b0) begin nFails++; $display("FAIL stall_we got=%b exp=0", phtBus.PHTWe); end
    nextCycle();
    offer(10'h0F1, 2'b11);
    FlushW = 1'b1;
    #1;
    nChecks++; if (phtBus.PHTWe !== 1'b0) begin nFails++; $display("FAIL flush_we got=%b exp=0", phtBus.PHTWe); end
    nextCycle();
    #1;
    nChecks++; if (QCount !== 3'd0) begin nFails++; $display("FAIL stall_qcount got=%0d exp=0", QCount); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] expWa [5];
    logic [1:0] expWd [5];
    int         expQ  [5];
    expWa = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h3C3};
    expWd = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    expQ  = '{4, 4, 3, 2, 1};
    doReset();
    runTo(10);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nextCycle();
      offer(10'h100 + 10'(i), 2'(i));
      #1;
      nChecks++;
      if (UpdDropped !== (i == 4)) begin nFails++; $display("FAIL fill_drop i=%0d got=%b exp=%0d", i, UpdDropped, i == 4); end
    end
    nextCycle();
    #1;
    nChecks++; if (QCount !== 3'd4) begin nFails++; $display("FAIL fill_qcount got=%0d exp=4", QCount); end
    nChecks++; if (UpdDropped !== 1'b0) begin nFails++; $display("FAIL fill_drop_after got=%b exp=0", UpdDropped); end
    runTo(1025);
    offer(10'h3C3, 2'b10);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nextCycle();
      #1;
      nChecks++; if (QCount !== 3'(expQ[i])) begin nFails++; $display("FAIL drain_qcount i=%0d got=%0d exp=%0d", i, QCount, expQ[i]); end
      nChecks++; if (phtBus.PHTWe !== 1'b1) begin nFails++; $display("FAIL drain_we i=%0d got=%b exp=1", i, phtBus.PHTWe); end
      nChecks++; if (phtBus.PHTWa !== expWa[i]) begin nFails++; $display("FAIL drain_wa i=%0d got=0x%03h exp=0x%03h", i, phtBus.PHTWa, expWa[i]); end
      nChecks++; if (phtBus.PHTWd !== expWd[i]) begin nFails++; $display("FAIL drain_wd i=%0d got=%b exp=%b", i, phtBus.PHTWd, expWd[i]); end
      nChecks++; if (UpdDropped !== 1'b0) begin nFails++; $display("FAIL drain_drop i=%0d got=%b exp=0", i, UpdDropped); end
    end
    nextCycle();
    #1;
    nChecks++; if (phtBus.PHTWe !== 1'b0) begin nFails++; $display("FAIL drain_idle_we got=%b exp=0", phtBus.PHTWe); end
    nChecks++; if (QCount !== 3'd0) begin nFails++; $display("FAIL drain_idle_qcount got=%0d exp=0", QCount); end
  endtask

  task automatic test_invalidate();
    doReset();
    runTo(20);
    offer(10'h011, 2'b11);
    nextCycle();
    offer(10'h022, 2'b00);
    runTo(301);
    InvalidateReq = 1'b1;
    offer(10'h033, 2'b11);
    #1;
    nChecks++; if (QCount !== 3'd2) begin nFails++; $display("FAIL inv_qcount_pre got=%0d exp=2", QCount); end
    nChecks++; if (phtBus.PHTWa !== 10'd300) begin nFails++; $display("FAIL inv_wa_pre got=%0d exp=300", phtBus.PHTWa); end
    nChecks++; if (UpdDropped !== 1'b0) begin nFails++; $display("FAIL inv_drop got=%b exp=0", UpdDropped); end
    nextCycle();
    #1;
    nChecks++; if (phtBus.PHTWa !== 10'd0) begin nFails++; $display("FAIL inv_wa_restart got=%0d exp=0", phtBus.PHTWa); end
    nChecks++; if (QCount !== 3'd0) begin nFails++; $display("FAIL inv_qcount got=%0d exp=0", QCount); end
    nChecks++; if (InitBusy !== 1'b1) begin nFails++; $display("FAIL inv_busy got=%b exp=1", InitBusy); end
    runTo(1325);
    #1;
    nChecks++; if (phtBus.PHTWa !== 10'd1023) begin nFails++; $display("FAIL inv_wa_last got=%0d exp=1023", phtBus.PHTWa); end
    nChecks++; if (InitBusy !== 1'b1) begin nFails++; $display("FAIL inv_busy_last got=%b exp=1", InitBusy); end
    nextCycle();
    #1;
    nChecks++; if (InitBusy !== 1'b0) begin nFails++; $display("FAIL inv_busy_done got=%b exp=0", InitBusy); end
    nChecks++; if (phtBus.PHTWe !== 1'b0) begin nFails++; $display("FAIL inv_we_done got=%b exp=0", phtBus.PHTWe); end
    $display("test_invalidate: restart sweep observed");
  endtask

  initial begin
    phtBus.UpdValid = 1'b0;
    phtBus.UpdIndex = '0;
    phtBus.UpdState = '0;
    test_reset();
    test_queue_during_sweep();
    test_bypass();
    test_back_to_back();
    test_invalidate();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
